// File: rtl/ext_bus_master_pkg.sv
// Shared EXT_BUS definitions: bus bit positions, responder command codes and
// the initiator FSM state encoding.
package ext_bus_master_pkg;

    localparam int BUS_W       = 36;
    localparam int DOUT_LSB    = 0;
    localparam int DOUT_MSB    = 15;
    localparam int DIN_LSB     = 16;
    localparam int DIN_MSB     = 31;
    localparam int DOUT_EN_BIT = 32;
    localparam int STROBE_BIT  = 33;
    localparam int ENABLE_BIT  = 34;

    localparam logic [15:0] GET_GROOVY_STATUS = 16'h00f0;
    localparam logic [15:0] GET_GROOVY_HPS    = 16'h00f1;
    localparam logic [15:0] SET_INIT          = 16'h00f2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAITWR,
        STROBE,
        SAMPLE,
        GAP,
        HOLD,
        RELEASE
    } state_t;

endpackage

// File: rtl/ext_bus_master_if.sv
// Request / write-stream / response bundle between an EXT_BUS initiator and
// its local client. master = the client issuing requests, slave = the initiator.
interface ext_bus_master_if #(
    parameter int LEN_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [15:0]      req_cmd;
    logic [LEN_W-1:0] req_len;
    logic             req_wr;

    logic             wr_valid;
    logic             wr_ready;
    logic [15:0]      wr_data;

    logic             rd_valid;
    logic [15:0]      rd_data;
    logic             rd_last;
    logic             done;
    logic             done_ack;

    modport master (
        output req_valid, req_cmd, req_len, req_wr, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_last, done, done_ack
    );

    modport slave (
        input  req_valid, req_cmd, req_len, req_wr, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_data, rd_last, done, done_ack
    );

endinterface

// File: rtl/ext_bus_pad.sv
// EXT_BUS pad: drives din/strobe/enable, releases the responder bits, captures dout/dout_en.
// Latency: drive bits are pass-through; captures land one cycle after cap_* is high.
// Backpressure: none; captured values hold until the next capture or clear.
module ext_bus_pad
    import ext_bus_master_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset_n,
    inout  wire  [BUS_W-1:0] ext_bus,
    input  logic             enable,
    input  logic             strobe,
    input  logic [15:0]      din,
    input  logic             cap_dout,
    input  logic             cap_ack,
    input  logic             clr_ack,
    output logic [15:0]      dout,
    output logic             ack
);

    // Bit order, MSB first: spare, enable, strobe, dout_en, din, dout.
    assign ext_bus = {1'bz, enable, strobe, 1'bz, din, 16'bz};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
            ack  <= 1'b0;
        end else begin
            if (cap_dout) begin
                dout <= ext_bus[DOUT_MSB:DOUT_LSB];
            end
            if (clr_ack) begin
                ack <= 1'b0;
            end else if (cap_ack) begin
                ack <= ext_bus[DOUT_EN_BIT];
            end
        end
    end

endmodule

// File: rtl/ext_bus_master.sv
// EXT_BUS initiator: one command word plus 0..31 data words per accepted request.
// Latency: first strobe GAP_CYCLES+1 cycles after accept; rd_valid 2 cycles after each strobe.
// Backpressure: req_ready only in IDLE; write words stall the strobe; no rd backpressure.
module ext_bus_master
    import ext_bus_master_pkg::*;
#(
    parameter int GAP_CYCLES = 3,
    parameter int LEN_W      = 5
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    inout  wire  [BUS_W-1:0] ext_bus,
    ext_bus_master_if.slave  host
);

    localparam int               CNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(GAP_CYCLES - 1);
    // SAMPLE already supplies one of the idle cycles after a strobe.
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [LEN_W-1:0] k;
    logic [LEN_W-1:0] len_q;
    logic [15:0]      cmd_q;
    logic             wr_q;
    logic             enable;
    logic             strobe;
    logic [15:0]      din;

    logic             accept;
    logic             word_ok;
    logic [15:0]      next_word;

    assign accept    = (state == IDLE) && host.req_valid;
    assign word_ok   = !wr_q || host.wr_valid;
    assign next_word = wr_q ? host.wr_data : 16'h0000;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            k              <= '0;
            len_q          <= '0;
            cmd_q          <= '0;
            wr_q           <= 1'b0;
            enable         <= 1'b0;
            strobe         <= 1'b0;
            din            <= '0;
            host.req_ready <= 1'b1;
            host.wr_ready  <= 1'b0;
            host.rd_valid  <= 1'b0;
            host.rd_last   <= 1'b0;
            host.done      <= 1'b0;
        end else begin
            strobe        <= 1'b0;
            host.wr_ready <= 1'b0;
            host.rd_valid <= 1'b0;
            host.rd_last  <= 1'b0;
            host.done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q          <= host.req_cmd;
                        len_q          <= host.req_len;
                        wr_q           <= host.req_wr;
                        k              <= '0;
                        cnt            <= CNT_FULL;
                        enable         <= 1'b1;
                        host.req_ready <= 1'b0;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        strobe <= 1'b1;
                        din    <= cmd_q;
                        state  <= STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAITWR: begin
                    if (host.wr_valid) begin
                        strobe        <= 1'b1;
                        din           <= host.wr_data;
                        host.wr_ready <= 1'b1;
                        state         <= STROBE;
                    end
                end
                STROBE: begin
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    host.rd_valid <= 1'b1;
                    host.rd_last  <= (k == len_q);
                    cnt           <= CNT_GAP;
                    state         <= GAP;
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (k == len_q) begin
                        cnt   <= CNT_FULL;
                        state <= HOLD;
                    end else begin
                        k <= k + 1'b1;
                        if (word_ok) begin
                            strobe        <= 1'b1;
                            din           <= next_word;
                            host.wr_ready <= wr_q;
                            state         <= STROBE;
                        end else begin
                            state <= WAITWR;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        enable <= 1'b0;
                        cnt    <= CNT_FULL;
                        state  <= RELEASE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    // Enable low long enough for the responder to clear its word counter.
                    if (cnt == '0) begin
                        host.req_ready <= 1'b1;
                        host.done      <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    ext_bus_pad u_pad (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ext_bus  (ext_bus),
        .enable   (enable),
        .strobe   (strobe),
        .din      (din),
        .cap_dout (state == SAMPLE),
        .cap_ack  ((state == SAMPLE) && (k == '0)),
        .clr_ack  (accept),
        .dout     (host.rd_data),
        .ack      (host.done_ack)
    );

endmodule

// File: tb/tb_ext_bus_master.sv
// Bench for ext_bus_master against a behavioural EXT_BUS responder model.
module tb_ext_bus_master;
    import ext_bus_master_pkg::*;

    localparam int GAP = 3;

    logic             clk_sys = 1'b0;
    logic             reset_n = 1'b0;
    wire  [BUS_W-1:0] ext_bus;

    ext_bus_master_if #(.LEN_W(5)) host ();

    ext_bus_master #(.GAP_CYCLES(GAP), .LEN_W(5)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ext_bus (ext_bus),
        .host    (host)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    // ---------------- responder model ----------------
    logic [15:0] rsp_dout = '0;
    logic        rsp_ack  = 1'b0;
    logic [15:0] rsp_cmd  = '0;
    logic [4:0]  rsp_cnt  = '0;
    logic        cmd_init = 1'b0;

    assign ext_bus = {1'bz, 1'bz, 1'bz, rsp_ack, 16'bz, rsp_dout};

    function automatic logic claimed(input logic [15:0] c);
        return (c == GET_GROOVY_STATUS) || (c == GET_GROOVY_HPS) || (c == SET_INIT);
    endfunction

    function automatic logic [15:0] rsp_word(input logic [15:0] c, input int idx);
        if (c == GET_GROOVY_STATUS) begin
            if (idx == 0) return 16'd7;
            if (idx == 1) return 16'd300;
            if (idx == 2) return 16'd12;
            return 16'h0F00 + 16'(idx);
        end
        if (c == GET_GROOVY_HPS) return 16'hA100 + 16'(idx);
        if (c == SET_INIT)       return 16'h0C00 + 16'(idx);
        return 16'h0000;
    endfunction

    always @(posedge clk_sys) begin
        if (ext_bus[ENABLE_BIT] !== 1'b1) begin
            rsp_cnt  <= '0;
            rsp_dout <= '0;
            rsp_ack  <= 1'b0;
        end else if (ext_bus[STROBE_BIT] === 1'b1) begin
            if (rsp_cnt == 0) begin
                rsp_cmd  <= ext_bus[DIN_MSB:DIN_LSB];
                rsp_ack  <= claimed(ext_bus[DIN_MSB:DIN_LSB]);
                rsp_dout <= rsp_word(ext_bus[DIN_MSB:DIN_LSB], 0);
            end else begin
                rsp_dout <= rsp_word(rsp_cmd, int'(rsp_cnt));
                if (rsp_cmd == SET_INIT && rsp_cnt == 5'd1) cmd_init <= ext_bus[DIN_LSB];
            end
            if (rsp_cnt != 5'd31) rsp_cnt <= rsp_cnt + 5'd1;
        end
    end

    // ---------------- bus monitor ----------------
    logic [16:0] got_q[$];
    int   rd_cnt = 0, done_cnt = 0, strobe_cnt = 0, wr_rdy_cnt = 0;
    int   width_err = 0, space_err = 0, wr_rdy_err = 0;
    int   low_run = 0, en_low_run = 0, rr_low_run = 0, rise_low_run = 0;
    logic prev_stb = 1'b0, prev_en = 1'b0, prev_rr = 1'b0, seen_stb = 1'b0;
    logic m_en, m_stb;

    always @(negedge clk_sys) begin
        m_en  = ext_bus[ENABLE_BIT];
        m_stb = ext_bus[STROBE_BIT];
        if (host.rd_valid) begin
            got_q.push_back({host.rd_last, host.rd_data});
            rd_cnt++;
        end
        if (host.done) done_cnt++;
        if (host.wr_ready) begin
            wr_rdy_cnt++;
            if (!m_stb) wr_rdy_err++;
        end
        if (m_stb) begin
            strobe_cnt++;
            if (prev_stb) width_err++;
            if (seen_stb && low_run < GAP) space_err++;
            low_run  = 0;
            seen_stb = 1'b1;
        end else begin
            low_run++;
        end
        if (!m_en) seen_stb = 1'b0;
        if (host.req_ready && !prev_rr) rr_low_run = en_low_run;
        if (m_en && !prev_en) rise_low_run = en_low_run;
        en_low_run = m_en ? 0 : en_low_run + 1;
        prev_stb = m_stb;
        prev_en  = m_en;
        prev_rr  = host.req_ready;
    end

    // ---------------- transaction driver + reference model ----------------
    int   strobes_at_wr = 0;
    logic exp_init = 1'b0;

    task automatic run_txn(input logic [15:0] cmd, input int len, input bit wr,
                           input int wr_delay, input logic [15:0] wfirst, input bit keep);
        int          t;
        int          d0;
        int          s0;
        logic [15:0] w;
        logic [16:0] exp;
        logic [16:0] got;
        got_q.delete();
        d0 = done_cnt;
        host.req_valid = 1'b1;
        host.req_cmd   = cmd;
        host.req_len   = 5'(len);
        host.req_wr    = wr;
        t = 0;
        while (!host.req_ready && t < 300) begin
            @(negedge clk_sys);
            t++;
        end
        check_eq("req_ready_seen", host.req_ready, 1);
        @(posedge clk_sys);
        #1;
        s0 = strobe_cnt;
        if (!keep) host.req_valid = 1'b0;
        if (wr) begin
            for (int j = 1; j <= len; j++) begin
                repeat (wr_delay) @(negedge clk_sys);
                #1;
                if (j == 1) strobes_at_wr = strobe_cnt - s0;
                w = (j == 1) ? wfirst : 16'($urandom);
                host.wr_valid = 1'b1;
                host.wr_data  = w;
                t = 0;
                do begin
                    @(negedge clk_sys);
                    t++;
                end while (!host.wr_ready && t < 300);
                check_eq("wr_ready_seen", host.wr_ready, 1);
                host.wr_valid = 1'b0;
            end
        end
        t = 0;
        while (!host.done && t < 3000) begin
            @(negedge clk_sys);
            t++;
        end
        check_eq("done_seen", host.done, 1);
        #1;
        check_eq("done_once", done_cnt - d0, 1);
        check_eq("rd_count", got_q.size(), len + 1);
        for (int i = 0; i <= len; i++) begin
            exp = {(i == len), claimed(cmd) ? rsp_word(cmd, (i > 31) ? 31 : i) : 16'h0000};
            got = (i < got_q.size()) ? got_q[i] : 17'hx;
            check_eq($sformatf("rd_word_%0d", i), got, exp);
        end
        check_eq("done_ack", host.done_ack, claimed(cmd));
        if (cmd == SET_INIT && len >= 1) exp_init = wr ? wfirst[0] : 1'b0;
        check_eq("cmd_init", cmd_init, exp_init);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int s0;
        int rv0;
        int dn0;
        int w0;
        logic [15:0] rc;

        host.req_valid = 1'b0;
        host.req_cmd   = '0;
        host.req_len   = '0;
        host.req_wr    = 1'b0;
        host.wr_valid  = 1'b0;
        host.wr_data   = '0;

        repeat (3) @(negedge clk_sys);
        check_eq("rst_enable", ext_bus[ENABLE_BIT], 0);
        check_eq("rst_strobe", ext_bus[STROBE_BIT], 0);
        check_eq("rst_din", ext_bus[DIN_MSB:DIN_LSB], 0);
        check_eq("rst_rd_valid", host.rd_valid, 0);
        check_eq("rst_done", host.done, 0);
        check_eq("rst_done_ack", host.done_ack, 0);
        check_eq("rst_wr_ready", host.wr_ready, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check_eq("rst_req_ready", host.req_ready, 1);

        // status read, with a stray wr stream that must be ignored
        w0 = wr_rdy_cnt;
        host.wr_valid = 1'b1;
        host.wr_data  = 16'($urandom);
        run_txn(GET_GROOVY_STATUS, 2, 1'b0, 0, 16'h0, 1'b0);
        check_eq("wr_ignored", wr_rdy_cnt - w0, 0);
        host.wr_valid = 1'b0;

        // SET_INIT with a late write word
        w0 = wr_rdy_cnt;
        run_txn(SET_INIT, 1, 1'b1, 10, 16'h0001, 1'b0);
        check_eq("strobe_waits_wr", strobes_at_wr, 1);
        check_eq("wr_ready_once", wr_rdy_cnt - w0, 1);
        check_eq("init_set", cmd_init, 1);

        // unclaimed command
        run_txn(16'h0055, 0, 1'b0, 0, 16'h0, 1'b0);
        check_eq("release_gap", rr_low_run, GAP);
        check_eq("idle_ready", host.req_ready, 1);

        // back-to-back with req_valid held high
        run_txn(GET_GROOVY_HPS, 1, 1'b0, 0, 16'h0, 1'b1);
        run_txn(GET_GROOVY_STATUS, 2, 1'b0, 0, 16'h0, 1'b0);
        check_eq("b2b_enable_gap", rise_low_run, GAP + 1);

        // async reset inside GAP of a len 3 transaction
        host.req_valid = 1'b1;
        host.req_cmd   = GET_GROOVY_STATUS;
        host.req_len   = 5'd3;
        host.req_wr    = 1'b0;
        t = 0;
        while (!host.req_ready && t < 300) begin
            @(negedge clk_sys);
            t++;
        end
        @(posedge clk_sys);
        #1;
        host.req_valid = 1'b0;
        s0 = strobe_cnt;
        t = 0;
        while (strobe_cnt < s0 + 2 && t < 200) begin
            @(negedge clk_sys);
            #1;
            t++;
        end
        check_eq("abort_strobes", strobe_cnt - s0, 2);
        @(negedge clk_sys);
        @(negedge clk_sys);
        #2;
        rv0 = rd_cnt;
        dn0 = done_cnt;
        reset_n = 1'b0;
        #1;
        check_eq("abort_enable", ext_bus[ENABLE_BIT], 0);
        check_eq("abort_strobe", ext_bus[STROBE_BIT], 0);
        check_eq("abort_rd_valid", host.rd_valid, 0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        #1;
        check_eq("abort_no_rd", rd_cnt - rv0, 0);
        check_eq("abort_no_done", done_cnt - dn0, 0);
        check_eq("abort_req_ready", host.req_ready, 1);
        run_txn(GET_GROOVY_HPS, 3, 1'b0, 0, 16'h0, 1'b0);

        // longest transaction
        rv0 = rd_cnt;
        run_txn(GET_GROOVY_HPS, 31, 1'b0, 0, 16'h0, 1'b0);
        check_eq("len31_rd_pulses", rd_cnt - rv0, 32);

        // randomized mix
        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(0, 3))
                0:       rc = GET_GROOVY_STATUS;
                1:       rc = GET_GROOVY_HPS;
                2:       rc = SET_INIT;
                default: rc = 16'h0100 | 16'($urandom_range(0, 255));
            endcase
            run_txn(rc, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 6), 16'($urandom), 1'b0);
        end

        check_eq("strobe_width", width_err, 0);
        check_eq("strobe_spacing", space_err, 0);
        check_eq("wr_ready_with_strobe", wr_rdy_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_bus_master.md
Name: ext_bus_master

Overview:
- Initiator (HPS-side) end of the 36-bit EXT_BUS command protocol; drives io_enable, io_strobe and io_din, and samples io_dout and dout_en.
- Sits in the FPGA for on-chip self-test and for local polling of ext responders (e.g. the Groovy status commands 'hf0..'hf2), and acts as a synthesizable bus driver for benches.
- Runs one transaction per request: a command word, then 0..31 data words.
- Returns the response captured after every strobe, plus the responder's acknowledge (dout_en).

Parameters:
- GAP_CYCLES, 3, idle cycles between strobes (min 1); also the enable setup/hold time.
- LEN_W, 5, width of the data-word count; matches the responder's saturating word counter.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ext_bus  inout  36  EXT_BUS; drives [31:16] io_din, [33] io_strobe, [34] io_enable; bits [15:0], [32] and [35] are always released (z); samples [15:0] io_dout and [32] dout_en
- req_valid  in  1  transaction request
- req_ready  out  1  high only in IDLE
- req_cmd  in  16  command word
- req_len  in  LEN_W  number of data words after the command
- req_wr  in  1  1 = data words come from the wr stream; 0 = send 16'h0000
- wr_valid  in  1  write word available
- wr_ready  out  1  write word consumed this cycle
- wr_data  in  16  write word
- rd_valid  out  1  one-cycle pulse; response word valid
- rd_data  out  16  io_dout sampled after a strobe
- rd_last  out  1  marks the response to the final word
- done  out  1  one-cycle pulse at end of transaction
- done_ack  out  1  dout_en sampled after the command strobe; held until the next request is accepted

Behaviour:
- Reset: all outputs 0, except req_ready, which is 1 once in IDLE. Driven bus bits are 0. Reset is async and may arrive mid-transaction: the FSM returns to IDLE and io_enable drops immediately, which the responder treats as an abort.
- Request acceptance:
  - Accept when req_valid && req_ready.
  - Latch cmd, len and wr.
  - Clear done_ack.
  - Word index k = 0.
- SETUP: drive io_enable = 1 for GAP_CYCLES cycles with strobe low, then go to STROBE.
- STROBE (1 cycle):
  - io_strobe = 1; io_din = cmd when k = 0, otherwise the data word.
  - For k >= 1 with wr = 1, STROBE is entered only when wr_valid = 1; until then the FSM waits in WAITWR with strobe low.
  - wr_ready pulses in the same cycle as that strobe.
  - io_din holds its value until the next strobe.
- SAMPLE: the cycle after the strobe.
  - Capture ext_bus[15:0] into rd_data.
  - rd_valid = 1 on the following cycle.
  - rd_last = (k == len).
  - When k = 0, capture ext_bus[32] into done_ack.
- GAP:
  - Strobe stays low for at least GAP_CYCLES cycles counted from the strobe.
  - Then k increments; go to STROBE/WAITWR if k <= len, otherwise HOLD.
- HOLD:
  - io_enable stays 1 for GAP_CYCLES cycles, then drops to 0.
  - Enable stays 0 for GAP_CYCLES cycles before returning to IDLE, so the responder resets its word counter.
  - done pulses on the IDLE entry cycle.
- Boundary conditions:
  - len = 0: only the command word is sent; rd_last is set on the first response.
  - len = 31: the responder's counter saturates; this is a legal transaction.
  - done_ack = 0 (no responder claimed the command): the transaction still completes and rd_data carries the sampled value (normally 0).
  - There is no rd backpressure; consumers must accept one word per transaction slot.
  - wr stream when req_wr = 0: ignored, wr_ready stays 0.
  - req_valid during a busy transaction: not accepted.

Decomposition:
- Shared package holds:
  - EXT bus bit positions (DOUT 15:0, DIN 31:16, DOUT_EN 32, STROBE 33, ENABLE 34).
  - Command codes GET_GROOVY_STATUS = 'hf0, GET_GROOVY_HPS = 'hf1, SET_INIT = 'hf2.
  - The FSM state enum {IDLE, SETUP, WAITWR, STROBE, SAMPLE, GAP, HOLD, RELEASE}.
- One sub-module: ext_bus_pad, which handles tri-state assignment of ext_bus and the input sampling register.
- The FSM and counters stay in the top module.

Test Plan:
- cmd 'hf0, len 2, wr 0, against a responder model returning 7 / vga_vcount 16'd300 / vga_frame 16'd12:
  - rd stream 7, 300, 12; rd_last on the third word.
  - done_ack = 1; done pulses once.
- cmd 'hf2, len 1, wr 1, with wr_data 16'h0001 presented 10 cycles late:
  - strobe is delayed until wr_valid; wr_ready pulses with the strobe.
  - the model's cmd_init becomes 1.
- cmd 'h55 (unclaimed), len 0: one rd word 0; done_ack = 0; io_enable low for GAP_CYCLES cycles before req_ready.
- Back-to-back requests with req_valid held high: second request accepted only after the enable-low gap; model byte counter restarts at 0.
- reset_n asserted during GAP of a len 3 transaction: io_enable = 0 and strobe = 0 asynchronously; no done or rd_valid; after release, req_ready = 1 and a new 'hf1 transaction returns correct data.
- Strobe spacing check across len 31: every strobe is exactly 1 cycle wide and strobes are >= GAP_CYCLES apart; 32 rd_valid pulses are produced.
